// File: rtl/seg_stopwatch_ctrl_if.sv
// rtl/seg_stopwatch_ctrl_if.sv - board-side buttons and display bundle for the stopwatch
interface seg_stopwatch_ctrl_if;
  logic [3:0] KEY;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [1:0] STATE;

  modport master (output KEY, input HEX0, HEX1, HEX2, HEX3, STATE);
  modport slave  (input KEY, output HEX0, HEX1, HEX2, HEX3, STATE);
endinterface

// File: rtl/seg_stopwatch_ctrl.sv
// rtl/seg_stopwatch_ctrl.sv - 4-digit BCD stopwatch with debounced start/stop and lap/clear buttons
module seg_stopwatch_ctrl #(
  parameter int TICK_DIV     = 500_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic            CLOCK_50,
  seg_stopwatch_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;

  logic key_rst_n;
  logic key3_unused;
  logic [1:0] rst_sync;
  logic rst_n;

  assign key_rst_n   = bus.KEY[0];
  assign key3_unused = bus.KEY[3];

  // Assert asynchronously, release only after two clean edges.
  always_ff @(posedge CLOCK_50 or negedge key_rst_n) begin
    if (!key_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Index 0 is start/stop (KEY[1]), index 1 is lap/clear (KEY[2]).
  logic [1:0]         sync1, sync2, deb, deb_q;
  logic [1:0][CW-1:0] deb_cnt;
  logic               start_ev, lap_ev;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb     <= 2'b11;
      deb_q   <= 2'b11;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.KEY[2:1];
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign start_ev = deb_q[0] & ~deb[0];
  assign lap_ev   = deb_q[1] & ~deb[1];

  state_t state, state_next;
  logic [PW-1:0]      presc;
  logic [3:0][3:0]    live, live_inc, lap_latch, disp;
  logic               active, tick, clear, enter_lap, carry;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Start has priority over lap when both fire together.
  always_comb begin
    state_next = state;
    if (start_ev) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        LAP:     state_next = PAUSE;
        default: state_next = IDLE;
      endcase
    end else if (lap_ev) begin
      case (state)
        RUN:     state_next = LAP;
        LAP:     state_next = RUN;
        PAUSE:   state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  assign active    = (state == RUN) || (state == LAP);
  assign tick      = active && (presc == PW'(TICK_DIV - 1));
  assign clear     = (state == PAUSE) && (state_next == IDLE);
  assign enter_lap = (state_next == LAP) && (state != LAP);

  always_comb begin
    live_inc = live;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (live[i] == 4'd9) begin
          live_inc[i] = 4'd0;
        end else begin
          live_inc[i] = live[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      live      <= '0;
      lap_latch <= '0;
    end else begin
      if (clear || state == IDLE) begin
        presc <= '0;
        live  <= '0;
      end else if (active) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) live <= live_inc;
      end
      if (enter_lap) lap_latch <= live;
    end
  end

  assign disp = (state == LAP) ? lap_latch : live;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign bus.HEX0  = seg7(disp[0]);
  assign bus.HEX1  = seg7(disp[1]);
  assign bus.HEX2  = seg7(disp[2]);
  assign bus.HEX3  = seg7(disp[3]);
  assign bus.STATE = state;

endmodule

// File: tb/tb_seg_stopwatch_ctrl.sv
// tb/tb_seg_stopwatch_ctrl.sv - self-checking bench for seg_stopwatch_ctrl
module tb_seg_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  seg_stopwatch_ctrl_if bus();
  seg_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEB)) dut (.CLOCK_50(clk), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [10];

  int cyc = 0;
  bit model_en = 0;
  int m_state, m_cycles, m_lap;
  int start_q[$];
  int lap_q[$];

  typedef struct {
    logic [1:0] keys;
    int         exp_state;
    string      name;
  } vec_t;
  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] exp_hex(input int value);
    logic [27:0] r;
    int v;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[7*i +: 7] = seg_tab[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int disp_value();
    logic [27:0] h;
    int v, d;
    h = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = -1;
      for (int k = 0; k < 10; k++) if (h[7*i +: 7] == seg_tab[k]) d = k;
      if (d < 0) return -1;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic int hex_all();
    return int'({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0});
  endfunction

  // Behavioural reference: elapsed active cycles determine the count.
  task automatic model_edge();
    int s, nxt, old_count;
    bit es, el;
    s  = m_state;
    es = 0;
    el = 0;
    if (start_q.size() > 0 && start_q[0] == cyc) begin es = 1; void'(start_q.pop_front()); end
    if (lap_q.size() > 0 && lap_q[0] == cyc) begin el = 1; void'(lap_q.pop_front()); end
    old_count = (m_cycles / TICK_DIV) % 10000;
    if (s == 1 || s == 3) m_cycles++;
    nxt = s;
    if (es) nxt = (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 1 : 2;
    else if (el) nxt = (s == 1) ? 3 : (s == 3) ? 1 : 0;
    if (s == 2 && nxt == 0) m_cycles = 0;
    if (nxt == 3 && s != 3) m_lap = old_count;
    m_state = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (model_en) begin
      model_edge();
      #1;
      chk("rand_state", int'(bus.STATE), m_state);
      chk("rand_hex", hex_all(),
          int'(exp_hex((m_state == 3) ? m_lap : (m_cycles / TICK_DIV) % 10000)));
    end else begin
      #1;
    end
  endtask

  task automatic set_keys(input logic [1:0] k);
    bus.KEY[1] = ~k[0];
    bus.KEY[2] = ~k[1];
  endtask

  task automatic do_reset();
    model_en = 0;
    bus.KEY = 4'b1110;
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_state", int'(bus.STATE), 0);
    chk("in_reset_hex", hex_all(), int'(exp_hex(0)));
    @(posedge clk);
    #2 bus.KEY[0] = 1'b1;
    repeat (3) step();
    chk("post_reset_state", int'(bus.STATE), 0);
    chk("post_reset_hex", hex_all(), int'(exp_hex(0)));
    cyc = 0; m_state = 0; m_cycles = 0; m_lap = 0;
    start_q.delete();
    lap_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, changes, lv[27];
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0]  = '{2'b01, 1, "idle_start"};
    vecs[1]  = '{2'b10, 3, "run_lap"};
    vecs[2]  = '{2'b10, 1, "lap_lap"};
    vecs[3]  = '{2'b01, 2, "run_start"};
    vecs[4]  = '{2'b01, 1, "pause_start"};
    vecs[5]  = '{2'b10, 3, "run_lap2"};
    vecs[6]  = '{2'b01, 2, "lap_start"};
    vecs[7]  = '{2'b10, 0, "pause_lap"};
    vecs[8]  = '{2'b10, 0, "idle_lap"};
    vecs[9]  = '{2'b11, 1, "idle_both"};
    vecs[10] = '{2'b11, 2, "run_both"};
    vecs[11] = '{2'b01, 1, "pause_start2"};
    vecs[12] = '{2'b10, 3, "run_lap3"};
    vecs[13] = '{2'b11, 2, "lap_both"};
    vecs[14] = '{2'b10, 0, "pause_clear"};
    bus.KEY = 4'b1111;

    // Start latency through synchronizer and debounce.
    do_reset();
    set_keys(2'b01);
    repeat (5) step();
    chk("start_latency_early", int'(bus.STATE), 0);
    step();
    chk("start_latency", int'(bus.STATE), 1);
    set_keys(2'b00);
    repeat (40) step();
    chk("run40_hex0", int'(bus.HEX0), int'(seg_tab[0]));
    chk("run40_hex1", int'(bus.HEX1), int'(seg_tab[1]));

    // Bouncing start key yields exactly one event.
    do_reset();
    lv = '{0,0,1,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    prev = 0;
    changes = 0;
    for (int i = 0; i < 27; i++) begin
      bus.KEY[1] = lv[i][0];
      step();
      if (i == 6) chk("bounce_no_event", int'(bus.STATE), 0);
      if (int'(bus.STATE) != prev) changes++;
      prev = int'(bus.STATE);
    end
    chk("bounce_changes", changes, 1);
    chk("bounce_state", int'(bus.STATE), 1);
    set_keys(2'b00);
    repeat (8) step();

    // FSM transition table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_keys(vecs[i].keys);
      repeat (8) step();
      chk(vecs[i].name, int'(bus.STATE), vecs[i].exp_state);
      set_keys(2'b00);
      repeat (8) step();
    end
    chk("clear_hex", hex_all(), int'(exp_hex(0)));

    // Lap freeze at 00.05 and resume.
    do_reset();
    set_keys(2'b01);
    repeat (8) step();
    set_keys(2'b00);
    repeat (14) step();
    set_keys(2'b10);
    repeat (6) step();
    chk("lap_state", int'(bus.STATE), 3);
    chk("lap_hex0_a", int'(bus.HEX0), int'(seg_tab[5]));
    set_keys(2'b00);
    repeat (20) step();
    chk("lap_hex0_b", int'(bus.HEX0), int'(seg_tab[5]));
    chk("lap_hex1", int'(bus.HEX1), int'(seg_tab[0]));
    chk("lap_state_b", int'(bus.STATE), 3);
    set_keys(2'b10);
    repeat (8) step();
    set_keys(2'b00);
    chk("lap_resume_state", int'(bus.STATE), 1);
    chk("lap_resume_ge10", int'(disp_value() >= 10), 1);
    repeat (8) step();

    // Randomized presses against the reference model.
    do_reset();
    model_en = 1;
    for (int a = 0; a < 90; a++) begin
      int kind, hold, gap;
      logic [1:0] k;
      kind = $urandom_range(0, 6);
      if (kind < 2) begin
        repeat ($urandom_range(1, 150)) step();
      end else begin
        k = (kind < 4) ? 2'b01 : (kind < 6) ? 2'b10 : 2'b11;
        hold = $urandom_range(4, 10);
        gap  = $urandom_range(6, 15);
        if (k[0]) start_q.push_back(cyc + 6);
        if (k[1]) lap_q.push_back(cyc + 6);
        set_keys(k);
        repeat (hold) step();
        set_keys(2'b00);
        repeat (gap) step();
      end
    end
    model_en = 0;

    // Asynchronous reset in LAP between clock edges.
    do_reset();
    set_keys(2'b01);
    repeat (8) step();
    set_keys(2'b00);
    repeat (20) step();
    set_keys(2'b10);
    repeat (8) step();
    set_keys(2'b00);
    chk("pre_async_lap", int'(bus.STATE), 3);
    @(posedge clk);
    #3 bus.KEY[0] = 1'b0;
    #1;
    chk("async_reset_state", int'(bus.STATE), 0);
    chk("async_reset_hex", hex_all(), int'(exp_hex(0)));

    // 99.99 wraps to 00.00.
    do_reset();
    set_keys(2'b01);
    for (int n = 1; n <= 40005; n++) begin
      step();
      if (n == 8) set_keys(2'b00);
    end
    chk("pre_wrap_hex", hex_all(), int'(exp_hex(9999)));
    step();
    chk("wrap_hex", hex_all(), int'(exp_hex(0)));
    chk("wrap_state", int'(bus.STATE), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
